traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 51 +++++
 rtl/traffic_phase_timer.sv | 36 +++
 rtl/traffic_phase_scheduler.sv | 148 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp patterns and lamp bit positions
// for the two-road intersection sequencer.
package traffic_pkg;

  localparam logic [2:0] PH_NS_G  = 3'd0;
  localparam logic [2:0] PH_NS_Y  = 3'd1;
  localparam logic [2:0] PH_RED_A = 3'd2;
  localparam logic [2:0] PH_EW_G  = 3'd3;
  localparam logic [2:0] PH_EW_Y  = 3'd4;
  localparam logic [2:0] PH_RED_B = 3'd5;

  typedef enum logic [2:0] {
    NS_G  = PH_NS_G,
    NS_Y  = PH_NS_Y,
    RED_A = PH_RED_A,
    EW_G  = PH_EW_G,
    EW_Y  = PH_EW_Y,
    RED_B = PH_RED_B
  } phase_e;

  localparam int unsigned L_NS_G = 5;
  localparam int unsigned L_NS_Y = 4;
  localparam int unsigned L_NS_R = 3;
  localparam int unsigned L_EW_G = 2;
  localparam int unsigned L_EW_Y = 1;
  localparam int unsigned L_EW_R = 0;

  localparam logic [5:0] LT_NS_G  = 6'b100001;
  localparam logic [5:0] LT_NS_Y  = 6'b010001;
  localparam logic [5:0] LT_RED_A = 6'b001001;
  localparam logic [5:0] LT_EW_G  = 6'b001100;
  localparam logic [5:0] LT_EW_Y  = 6'b001010;
  localparam logic [5:0] LT_RED_B = 6'b001001;

  // Lamp pattern for a phase; unknown codes show the resting pattern.
  function automatic logic [5:0] light_of(input phase_e p);
    logic [5:0] l;
    l = LT_NS_G;
    case (p)
      NS_G:    l = LT_NS_G;
      NS_Y:    l = LT_NS_Y;
      RED_A:   l = LT_RED_A;
      EW_G:    l = LT_EW_G;
      EW_Y:    l = LT_EW_Y;
      RED_B:   l = LT_RED_B;
      default: l = LT_NS_G;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Saturating phase dwell counter with synchronous
// clear (phase change) and synchronous reset.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  output logic [TW-1:0] o_cnt
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Count up, hold at all-ones, restart on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven NS/EW light sequencer with all-red clearance.
// Optional pedestrian walk interval: define PED_WALK_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int NS_GREEN_MIN = 8,
  parameter int EW_GREEN     = 6,
  parameter int YELLOW       = 3,
  parameter int ALL_RED      = 1,
  parameter int TW           = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ew_req,
`ifdef PED_WALK_EN
  input  logic       i_ped_req,
  output logic       o_walk,
`endif
  output logic [5:0] o_light,
  output logic [2:0] o_state,
  output logic       o_req_pending
);

  localparam logic [TW-1:0] NSG_LAST = TW'(NS_GREEN_MIN - 1);
  localparam logic [TW-1:0] EWG_LAST = TW'(EW_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW - 1);
  localparam logic [TW-1:0] RED_LAST = TW'(ALL_RED - 1);

  phase_e        state_q;
  phase_e        state_d;
  logic [5:0]    light_q;
  logic          req_q;
  logic          req_d;
  logic [TW-1:0] timer;
  logic          phase_chg;
  logic          go;
  logic [TW-1:0] reda_last;
  logic          enter_ewg;

`ifdef PED_WALK_EN
  localparam logic [TW-1:0] WALK_LAST = TW'(ALL_RED + 3);

  logic ped_q;
  logic ped_d;
  logic walk_q;
  logic walk_d;

  assign go        = req_q | i_ew_req | ped_q | i_ped_req;
  assign reda_last = walk_q ? WALK_LAST : RED_LAST;
`else
  assign go        = req_q | i_ew_req;
  assign reda_last = RED_LAST;
`endif

  // Next phase from current phase, dwell timer and demand.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_G: begin
        if (timer >= NSG_LAST && go) state_d = NS_Y;
      end
      NS_Y: begin
        if (timer == YEL_LAST) state_d = RED_A;
      end
      RED_A: begin
        if (timer == reda_last) state_d = EW_G;
      end
      EW_G: begin
        if (timer == EWG_LAST) state_d = EW_Y;
      end
      EW_Y: begin
        if (timer == YEL_LAST) state_d = RED_B;
      end
      RED_B: begin
        if (timer == RED_LAST) state_d = NS_G;
      end
      default: state_d = NS_G;
    endcase
  end

  assign phase_chg = (state_d != state_q);
  assign enter_ewg = (state_d == EW_G) && (state_q != EW_G);

  // EW demand latch: entering EW green clears it and wins.
  always_comb begin
    req_d = req_q;
    if (enter_ewg) begin
      req_d = 1'b0;
    end else if (i_ew_req && state_q != EW_G) begin
      req_d = 1'b1;
    end
  end

`ifdef PED_WALK_EN
  // Ped latch and walk interval, both tied to the RED_A span.
  always_comb begin
    ped_d  = ped_q | i_ped_req;
    walk_d = walk_q;
    if (state_d == RED_A && state_q != RED_A) begin
      walk_d = ped_q;
    end
    if (state_q == RED_A && state_d != RED_A) begin
      ped_d  = 1'b0;
      walk_d = 1'b0;
    end
  end

  // Ped registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ped_q  <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      ped_q  <= ped_d;
      walk_q <= walk_d;
    end
  end

  assign o_walk = walk_q;
`endif

  phase_timer #(
    .TW (TW)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (phase_chg),
    .o_cnt (timer)
  );

  // Phase register with registered lamp decode and latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= NS_G;
      light_q <= LT_NS_G;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light_of(state_d);
      req_q   <= req_d;
    end
  end

  assign o_light       = light_q;
  assign o_state       = state_q;
  assign o_req_pending = req_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed table,
// corner sequences and random demand vs. a phase model.
module tb_traffic_phase_scheduler;

  localparam int NSG = 8;
  localparam int EWG = 6;
  localparam int YEL = 3;
  localparam int ARD = 1;
  localparam int TW  = 8;

  logic       i_clk;
  logic       i_rst;
  logic       i_ew_req;
  logic [5:0] o_light;
  logic [2:0] o_state;
  logic       o_req_pending;
`ifdef PED_WALK_EN
  logic       o_walk;
`endif

  int errors = 0;
  int checks = 0;
  bit armed  = 0;

  traffic_phase_scheduler #(
    .NS_GREEN_MIN (NSG),
    .EW_GREEN     (EWG),
    .YELLOW       (YEL),
    .ALL_RED      (ARD),
    .TW           (TW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ew_req      (i_ew_req),
`ifdef PED_WALK_EN
    .i_ped_req     (1'b0),
    .o_walk        (o_walk),
`endif
    .o_light       (o_light),
    .o_state       (o_state),
    .o_req_pending (o_req_pending)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [5:0] lp [6];
  initial begin
    lp[0] = 6'b100001;
    lp[1] = 6'b010001;
    lp[2] = 6'b001001;
    lp[3] = 6'b001100;
    lp[4] = 6'b001010;
    lp[5] = 6'b001001;
  end

  // Reference: phase index, cycles spent in it, pending flag.
  int m_ph;
  int m_age;
  bit m_pend;

  function automatic int dwell(input int ph);
    case (ph)
      1: return YEL;
      2: return ARD;
      3: return EWG;
      4: return YEL;
      5: return ARD;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit req);
    int nxt;
    if (rst) begin
      m_ph = 0; m_age = 0; m_pend = 0;
      return;
    end
    nxt = m_ph;
    if (m_ph == 0) begin
      if (m_age >= NSG - 1 && (m_pend || req)) nxt = 1;
    end else if (m_age == dwell(m_ph) - 1) begin
      nxt = (m_ph + 1) % 6;
    end
    if (nxt == 3 && m_ph != 3) m_pend = 0;
    else if (req && m_ph != 3) m_pend = 1;
    if (nxt != m_ph) m_age = 0;
    else m_age++;
    m_ph = nxt;
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, edge, update model, compare on negedge.
  task automatic tick(input bit rst, input bit req);
    i_rst    = rst;
    i_ew_req = req;
    @(posedge i_clk);
    model_step(rst, req);
    @(negedge i_clk);
    chk("model_state", {5'd0, o_state}, 8'(m_ph));
    chk("model_light", {2'd0, o_light}, {2'd0, lp[m_ph]});
    chk("model_pend", {7'd0, o_req_pending}, {7'd0, m_pend});
  endtask

  task automatic run_until(input int ph, input int bound);
    int n;
    n = 0;
    while (o_state != 3'(ph) && n < bound) begin
      tick(0, 0);
      n++;
    end
    chk("reach_phase", {5'd0, o_state}, 8'(ph));
  endtask

  // Lamp sanity every cycle once reset has been applied.
  always @(negedge i_clk) begin
    if (armed) begin
      checks++;
      if (((o_light[5] | o_light[4]) && (o_light[2] | o_light[1]))
          || !$onehot(o_light[5:3]) || !$onehot(o_light[2:0])) begin
        errors++;
        $display("FAIL lamp_safety: light=%b at %0t", o_light, $time);
      end
    end
  end

  typedef struct {
    bit req;
    int n;
    int st;
    bit pend;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    tbl[0]  = '{0, 2, 0, 0};
    tbl[1]  = '{1, 1, 0, 1};
    tbl[2]  = '{0, 4, 0, 1};
    tbl[3]  = '{0, 1, 1, 1};
    tbl[4]  = '{0, 2, 1, 1};
    tbl[5]  = '{0, 1, 2, 1};
    tbl[6]  = '{0, 1, 3, 0};
    tbl[7]  = '{0, 5, 3, 0};
    tbl[8]  = '{0, 1, 4, 0};
    tbl[9]  = '{0, 2, 4, 0};
    tbl[10] = '{0, 1, 5, 0};
    tbl[11] = '{0, 1, 0, 0};
    tbl[12] = '{0, 20, 0, 0};

    i_rst = 1'b1;
    i_ew_req = 1'b0;
    m_ph = 0; m_age = 0; m_pend = 0;
    @(negedge i_clk);

    // Reset held three cycles.
    tick(1, 0);
    armed = 1;
    tick(1, 0);
    tick(1, 0);
    chk("rst_light", {2'd0, o_light}, 8'h21);
    chk("rst_state", {5'd0, o_state}, 8'd0);
    chk("rst_pend", {7'd0, o_req_pending}, 8'd0);

    // Single request pulsed at cycle 2: full directed cycle.
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        tick(0, (j == 0) ? tbl[i].req : 1'b0);
        chk($sformatf("tbl%0d_state", i), {5'd0, o_state}, 8'(tbl[i].st));
        chk($sformatf("tbl%0d_pend", i), {7'd0, o_req_pending},
            {7'd0, tbl[i].pend});
        chk($sformatf("tbl%0d_light", i), {2'd0, o_light},
            {2'd0, lp[tbl[i].st]});
      end
    end

    // Idle 300 cycles, then a request must still leave at once.
    tick(1, 0);
    for (int i = 0; i < 300; i++) tick(0, 0);
    chk("hold300_state", {5'd0, o_state}, 8'd0);
    tick(1, 0);
    for (int i = 0; i < 258; i++) tick(0, 0);
    tick(0, 1);
    chk("sat_exit", {5'd0, o_state}, 8'd1);

    // Late request at cycle 50.
    tick(1, 0);
    for (int i = 0; i < 50; i++) tick(0, 0);
    tick(0, 1);
    chk("late_req", {5'd0, o_state}, 8'd1);

    // Request during EW green is dropped.
    run_until(3, 20);
    tick(0, 0);
    tick(0, 1);
    chk("ewg_req_ign", {7'd0, o_req_pending}, 8'd0);
    run_until(0, 20);
    for (int i = 0; i < 40; i++) tick(0, 0);
    chk("ewg_stay", {5'd0, o_state}, 8'd0);

    // Request in EW yellow: second cycle after 8 NS_G cycles.
    tick(0, 1);
    run_until(4, 30);
    tick(0, 1);
    chk("ewy_latch", {7'd0, o_req_pending}, 8'd1);
    run_until(0, 20);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      tick(0, 0);
      if (o_state != 3'd0) break;
      n++;
    end
    chk("ewy_nsg_len", 8'(n), 8'(NSG));
    chk("ewy_next", {5'd0, o_state}, 8'd1);

    // Reset in the middle of EW green.
    run_until(3, 20);
    tick(0, 0);
    tick(1, 1);
    chk("midrst_light", {2'd0, o_light}, 8'h21);
    chk("midrst_pend", {7'd0, o_req_pending}, 8'd0);
    chk("midrst_state", {5'd0, o_state}, 8'd0);

    // Random demand with rare resets.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 599) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
